// File: rtl/mux_sel_sequencer.sv
// Round-robin select generator for a 4:1 mux: one-hot grant plus {s1,s2}, each slot DWELL clocks.
// Optional MUX_SEL_HOLD_EN adds a hold input that stretches the final cycle of a slot.
module mux_sel_sequencer #(
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req,
`ifdef MUX_SEL_HOLD_EN
  input  logic       hold,
`endif
  output logic       s1,
  output logic       s2,
  output logic [3:0] gnt,
  output logic       valid,
  output logic       slot_done
);

  localparam int CW = $clog2(DWELL + 1);
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    ptr;
  logic [1:0]    sel;
  logic [1:0]    pick;
  logic [1:0]    cand;
  logic          hold_i;
  logic          final_c;
  logic          end_slot;
  logic          start;
  logic          grant_now;

`ifdef MUX_SEL_HOLD_EN
  assign hold_i = hold;
`else
  assign hold_i = 1'b0;
`endif

  assign {s1, s2} = sel;

  // First requester after the last-served channel; ptr itself is the last candidate.
  always_comb begin
    pick = ptr;
    cand = ptr;
    for (int i = 4; i >= 1; i--) begin
      cand = ptr + 2'(i);
      if (req[cand]) pick = cand;
    end
  end

  assign final_c   = (cnt == LAST);
  assign end_slot  = !req[sel] || (final_c && !hold_i);
  assign start     = en && (|req);
  assign grant_now = start && ((state == IDLE) || end_slot);

  // The final-cycle state is registered; gating with live req/hold keeps a
  // same-cycle abort or hold from ever showing a completion pulse.
  assign slot_done = valid && final_c && req[sel] && !hold_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      ptr   <= 2'd3;
      sel   <= 2'd0;
      valid <= 1'b0;
      gnt   <= 4'b0000;
    end else if (grant_now) begin
      state <= GRANT;
      cnt   <= '0;
      ptr   <= pick;
      sel   <= pick;
      valid <= 1'b1;
      gnt   <= 4'b0001 << pick;
    end else if (state == GRANT) begin
      if (end_slot) begin
        state <= IDLE;
        cnt   <= '0;
        valid <= 1'b0;
        gnt   <= 4'b0000;
      end else if (!final_c) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
